// File: rtl/data_mem_arbiter_if.sv
// One requester's view of the shared data memory: req/ack handshake with
// write data in and read data plus error flag back.
interface data_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic          err;
  logic [DW-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  err,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output err,
    output rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing a single-port, combinational-read data memory
// between the CPU load/store path (port 0) and a loader/debug master (port 1).
module data_mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_arbiter_if.slave p0,
  data_mem_arbiter_if.slave p1,
  output logic [AW-1:0]     mem_a,
  output logic              mem_we,
  output logic [DW-1:0]     mem_wd,
  input  logic [DW-1:0]     mem_rd,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]    req_vec;
  logic [1:0]    we_vec;
  logic [AW-1:0] addr_arr  [2];
  logic [DW-1:0] wdata_arr [2];

  assign req_vec      = {p1.req, p0.req};
  assign we_vec       = {p1.we, p0.we};
  assign addr_arr[0]  = p0.addr;
  assign addr_arr[1]  = p1.addr;
  assign wdata_arr[0] = p0.wdata;
  assign wdata_arr[1] = p1.wdata;

  logic          grant_valid;
  logic          winner_next;
  logic          last_grant_reg;
  logic          winner_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;

  logic          acc_err;
  logic [AW-1:0] word_idx;

  logic [1:0]    ack_vec;
  logic [1:0]    err_vec;
  logic [DW-1:0] rdata_arr [2];

  // Next state and grant decision; on a tie the port that did not win last goes.
  always_comb begin
    state_next  = state_reg;
    grant_valid = 1'b0;
    winner_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          grant_valid = 1'b1;
          if (&req_vec) begin
            winner_next = ~last_grant_reg;
          end else begin
            winner_next = req_vec[1];
          end
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      winner_reg     <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_valid) begin
        last_grant_reg <= winner_next;
        winner_reg     <= winner_next;
        we_reg         <= we_vec[winner_next];
        addr_reg       <= addr_arr[winner_next];
        wdata_reg      <= wdata_arr[winner_next];
      end
    end
  end

  // Misaligned or beyond the last word: the access is suppressed and flagged.
  assign word_idx = {2'b00, addr_reg[AW-1:2]};
  assign acc_err  = (addr_reg[1:0] != 2'b00) || (word_idx >= AW'(MEM_WORDS));

  // Reset gates the strobe so an aborted write never lands in memory.
  always_comb begin
    mem_a  = '0;
    mem_wd = '0;
    mem_we = 1'b0;
    if (state_reg == ACCESS) begin
      mem_a  = addr_reg;
      mem_wd = wdata_reg;
      mem_we = we_reg & ~acc_err & ~reset;
    end
  end

  assign busy = (state_reg != IDLE);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_port
      logic          ack_reg;
      logic          err_reg;
      logic [DW-1:0] rdata_reg;
      logic          is_winner;

      assign is_winner = (winner_reg == 1'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= '0;
        end else if (state_reg == ACCESS && is_winner) begin
          ack_reg <= 1'b1;
          err_reg <= acc_err;
          // Writes leave the last read value in place.
          if (!we_reg) begin
            rdata_reg <= acc_err ? '0 : mem_rd;
          end
        end else if (state_reg == RESP) begin
          ack_reg <= 1'b0;
          err_reg <= 1'b0;
        end
      end

      assign ack_vec[gi]   = ack_reg;
      assign err_vec[gi]   = err_reg;
      assign rdata_arr[gi] = rdata_reg;
    end
  endgenerate

  assign p0.ack   = ack_vec[0];
  assign p0.err   = err_vec[0];
  assign p0.rdata = rdata_arr[0];
  assign p1.ack   = ack_vec[1];
  assign p1.err   = err_vec[1];
  assign p1.rdata = rdata_arr[1];

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a vector table of single accesses plus
// hand sequences for fairness, back-to-back service and reset mid-access.
module tb_data_mem_arbiter;
  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MEM_WORDS = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] mem_a;
  logic          mem_we;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          busy;

  data_mem_arbiter_if #(.AW(AW), .DW(DW)) p0_bus ();
  data_mem_arbiter_if #(.AW(AW), .DW(DW)) p1_bus ();

  data_mem_arbiter #(.AW(AW), .DW(DW), .MEM_WORDS(MEM_WORDS)) dut (
    .clk    (clk),
    .reset  (reset),
    .p0     (p0_bus),
    .p1     (p1_bus),
    .mem_a  (mem_a),
    .mem_we (mem_we),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd),
    .busy   (busy)
  );

  // Behavioural data memory: combinational read, write on posedge.
  logic [DW-1:0] mem [MEM_WORDS];
  logic          mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'hA5A5_0000 | i;
    end else if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
    end
  end
  assign mem_rd = mem[mem_a[7:2]];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_port(input int p, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      p0_bus.req = req; p0_bus.we = we; p0_bus.addr = addr; p0_bus.wdata = wdata;
    end else begin
      p1_bus.req = req; p1_bus.we = we; p1_bus.addr = addr; p1_bus.wdata = wdata;
    end
  endtask

  function automatic logic get_ack(input int p);
    return (p == 0) ? p0_bus.ack : p1_bus.ack;
  endfunction

  function automatic logic get_err(input int p);
    return (p == 0) ? p0_bus.err : p1_bus.err;
  endfunction

  function automatic logic [31:0] get_rdata(input int p);
    return (p == 0) ? p0_bus.rdata : p1_bus.rdata;
  endfunction

  task automatic do_reset(input logic init_mem);
    @(negedge clk);
    reset    = 1'b1;
    mem_init = init_mem;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    mem_init = 1'b0;
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic run_vec(input int idx, input vec_t v);
    int          n;
    int          we_cnt;
    logic        got_ack;
    logic        other_ack;
    logic [31:0] a_at_we;
    @(negedge clk);
    drive_port(v.port, 1'b1, v.we, v.addr, v.wdata);
    n = 0; we_cnt = 0; got_ack = 1'b0; other_ack = 1'b0; a_at_we = '0;
    while (!got_ack && n < 10) begin
      @(negedge clk);
      n++;
      if (mem_we) begin
        we_cnt++;
        a_at_we = mem_a;
      end
      if (get_ack(1 - v.port)) other_ack = 1'b1;
      if (get_ack(v.port)) got_ack = 1'b1;
    end
    chk($sformatf("v%0d ack_seen", idx), 32'(got_ack), 32'd1);
    chk($sformatf("v%0d latency", idx), n, 32'd2);
    chk($sformatf("v%0d err", idx), 32'(get_err(v.port)), 32'(v.exp_err));
    if (!v.we) chk($sformatf("v%0d rdata", idx), get_rdata(v.port), v.exp_rdata);
    chk($sformatf("v%0d mem_we_cycles", idx), we_cnt, (v.we && !v.exp_err) ? 32'd1 : 32'd0);
    if (we_cnt != 0) chk($sformatf("v%0d mem_a", idx), a_at_we, v.addr);
    chk($sformatf("v%0d other_ack", idx), 32'(other_ack), 32'd0);
    drive_port(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk($sformatf("v%0d ack_pulse_end", idx), 32'(get_ack(v.port)), 32'd0);
    chk($sformatf("v%0d busy_end", idx), 32'(busy), 32'd0);
    $display("vec %0d: port %0d %s addr=%h wdata=%h err=%0d rdata=%h latency=%0d",
             idx, v.port, v.we ? "WR" : "RD", v.addr, v.wdata,
             get_err(v.port), get_rdata(v.port), n);
  endtask

  initial begin
    int ack_n    [6];
    int ack_port [6];
    int n_acks;
    int n;
    logic p1_dirty;

    vecs[0]  = '{0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1, 1'b1, 32'h0000_0006, 32'h1234_5678, 1'b1, 32'h0};
    vecs[3]  = '{1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 1'b1, 32'h0};
    vecs[4]  = '{0, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'hA5A5_0001};
    vecs[5]  = '{1, 1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'hA5A5_003F};
    vecs[6]  = '{0, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0};
    vecs[7]  = '{1, 1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0};
    vecs[8]  = '{1, 1'b1, 32'h0000_00FC, 32'h0BAD_F00D, 1'b0, 32'h0};
    vecs[9]  = '{0, 1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'h0BAD_F00D};
    vecs[10] = '{0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_0000};
    vecs[11] = '{1, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'hA5A5_0001};

    reset    = 1'b1;
    mem_init = 1'b1;
    drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    do_reset(1'b1);

    // Reset state
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_a", mem_a, 32'h0);
    chk("rst mem_wd", mem_wd, 32'h0);
    chk("rst p0_ack", 32'(p0_bus.ack), 32'd0);
    chk("rst p0_err", 32'(p0_bus.err), 32'd0);
    chk("rst p0_rdata", p0_bus.rdata, 32'h0);
    chk("rst p1_ack", 32'(p1_bus.ack), 32'd0);
    chk("rst p1_err", 32'(p1_bus.err), 32'd0);
    chk("rst p1_rdata", p1_bus.rdata, 32'h0);
    $display("reset: busy=%0d mem_we=%0d", busy, mem_we);

    // Single requester holding req: one ack every 3 cycles, port 1 stays quiet
    @(negedge clk);
    drive_port(0, 1'b1, 1'b0, 32'h0, 32'h0);
    n = 0; n_acks = 0; p1_dirty = 1'b0;
    while (n_acks < 3 && n < 20) begin
      @(negedge clk);
      n++;
      if (p1_bus.ack || p1_bus.err || p1_bus.rdata != 32'h0) p1_dirty = 1'b1;
      if (p0_bus.ack) begin
        ack_n[n_acks] = n;
        n_acks++;
      end
    end
    drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("single n_acks", n_acks, 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < n_acks) chk($sformatf("single ack%0d cycle", i), ack_n[i], 32'(2 + 3 * i));
    end
    chk("single p0_rdata", p0_bus.rdata, 32'hA5A5_0000);
    chk("single p1_quiet", 32'(p1_dirty), 32'd0);
    $display("single: %0d acks on p0, p1 quiet=%0d", n_acks, !p1_dirty);
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset asserted while a write is in its ACCESS cycle
    @(negedge clk);
    drive_port(0, 1'b1, 1'b1, 32'h0000_0010, 32'h1111_2222);
    @(negedge clk);
    chk("abort busy_in_access", 32'(busy), 32'd1);
    chk("abort mem_we_pre", 32'(mem_we), 32'd1);
    reset = 1'b1;
    drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("abort mem_we_gated", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("abort ack", 32'(p0_bus.ack), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort ack_after", 32'(p0_bus.ack), 32'd0);
    chk("abort word4", mem[4], 32'hA5A5_0004);
    $display("abort: word4=%h busy=%0d", mem[4], busy);
    run_vec(12, '{0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hA5A5_0004});

    // Both ports requesting from reset: strict alternation starting with port 0
    do_reset(1'b0);
    drive_port(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
    drive_port(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
    n = 0; n_acks = 0;
    while (n_acks < 6 && n < 40) begin
      @(negedge clk);
      n++;
      if (p0_bus.ack && p1_bus.ack) begin
        chk("fair double_ack", 32'd1, 32'd0 + 32'(p0_bus.ack & ~p1_bus.ack));
      end
      if (p0_bus.ack || p1_bus.ack) begin
        ack_n[n_acks]    = n;
        ack_port[n_acks] = p1_bus.ack ? 1 : 0;
        chk($sformatf("fair rdata%0d", n_acks), get_rdata(ack_port[n_acks]),
            ack_port[n_acks] == 1 ? 32'hA5A5_0001 : 32'hA5A5_0000);
        $display("fair: grant %0d to port %0d at cycle %0d", n_acks, ack_port[n_acks], n);
        n_acks++;
      end
    end
    drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("fair n_acks", n_acks, 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < n_acks) begin
        chk($sformatf("fair port%0d", i), ack_port[i], 32'(i % 2));
        chk($sformatf("fair cycle%0d", i), ack_n[i], 32'(2 + 3 * i));
      end
    end
    repeat (2) @(negedge clk);
    chk("fair idle_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
